// File: rtl/taylor_pkg.sv
// Shared constants, state encoding and saturating accumulate helper for the
// eight-term power-series evaluator.
package taylor_pkg;
    localparam int NTERMS = 8;
    localparam int DW     = 16;
    localparam int CNT_W  = 3;
    localparam int ACC_W  = 18;

    localparam logic [ACC_W-1:0] ACC_MAX  = 18'h3FFFF;
    localparam logic [DW-1:0]    P_ONE    = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTERMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Terms are never negative, so clamping each partial sum keeps acc pinned
    // at ACC_MAX once it has been reached.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [DW-1:0]    b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W-DW+1){1'b0}}, b};
        if (sum > {1'b0, ACC_MAX}) begin
            sat_add = ACC_MAX;
        end else begin
            sat_add = sum[ACC_W-1:0];
        end
    endfunction
endpackage

// File: rtl/taylor_datapath.sv
// Operand, running power and saturating accumulator for the series evaluator;
// i_init loads a new evaluation, i_step folds in one coefficient.
module taylor_datapath
    import taylor_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_init,
    input  logic             i_step,
    input  logic [DW-1:0]    i_x,
    input  logic [DW-1:0]    i_coef,
    output logic [ACC_W-1:0] o_acc
);
    logic [DW-1:0]    r_xr;
    logic [DW-1:0]    r_p;
    logic [ACC_W-1:0] r_acc;

    logic [2*DW-1:0]  w_term_prod;
    logic [2*DW-1:0]  w_pow_prod;
    logic [DW-1:0]    w_term;
    logic [DW-1:0]    w_pow_next;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_unused_lo;

    // Both products keep only their upper halves (floor of the Q0.16 product).
    always_comb begin
        w_term_prod = {{DW{1'b0}}, i_coef} * {{DW{1'b0}}, r_p};
        w_pow_prod  = {{DW{1'b0}}, r_p} * {{DW{1'b0}}, r_xr};
        w_term      = w_term_prod[2*DW-1:DW];
        w_pow_next  = w_pow_prod[2*DW-1:DW];
        w_acc_next  = sat_add(r_acc, w_term);
        w_unused_lo = ^{w_term_prod[DW-1:0], w_pow_prod[DW-1:0]};
    end

    // Datapath registers: load on init, advance on step, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xr  <= {DW{1'b0}};
            r_p   <= {DW{1'b0}};
            r_acc <= {ACC_W{1'b0}};
        end else if (i_init) begin
            r_xr  <= i_x;
            r_p   <= P_ONE;
            r_acc <= {ACC_W{1'b0}};
        end else if (i_step) begin
            r_xr  <= r_xr;
            r_p   <= w_pow_next;
            r_acc <= w_acc_next;
        end else begin
            r_xr  <= r_xr;
            r_p   <= r_p;
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/taylor_eval.sv
// Sequencer for an eight-term power series: walks the coefficient ROM address
// and drives the datapath, returning one saturated Q2.16 sum per start.
module taylor_eval
    import taylor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    x,
    output logic [CNT_W-1:0] rom_adr,
    input  logic [DW-1:0]    rom_data,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result
);
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_init;
    logic             w_step;
    logic [ACC_W-1:0] w_acc;

    // Next-state and datapath strobes; start outside IDLE is simply dropped.
    always_comb begin
        w_state_next = r_state;
        w_init       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = CALC;
                    w_init       = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CALC;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Term counter; stops at the last address and holds it until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_init) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_step && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    taylor_datapath u_datapath (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_init  (w_init),
        .i_step  (w_step),
        .i_x     (x),
        .i_coef  (rom_data),
        .o_acc   (w_acc)
    );

    assign rom_adr = r_cnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = w_acc;
endmodule
